// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam int INSTR_BYTES  = 4;
    localparam int ENTRY_ADDR_W = 32;
    localparam int ENTRY_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] pc;
        logic [ENTRY_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetched {pc, instr} pairs with flush
module fetch_fifo #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_instr,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_instr,
    output logic [CNT_W-1:0]  count
);

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_pop;

    assign do_pop     = pop && (count != '0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    // Flush discards occupancy but keeps storage; only reset zeroes the head.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush && push) begin
            assert (count != CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetcher feeding decode through a FIFO
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] redirect_target;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              stay_busy;

    assign imem_req        = (state == BUSY) || (state == FLUSH);
    assign imem_addr       = req_addr;
    assign inst_valid      = (count != '0);
    assign pop             = inst_valid && inst_ready;
    assign push            = (state == BUSY) && imem_ack && !redirect_valid;
    assign next_pc         = fetch_pc + STEP;
    assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
    // After this cycle's push there is still room if a pop frees a slot or we were two short.
    assign stay_busy       = pop || (count < FULL_COUNT - 1'b1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
            end
            case (state)
                IDLE: begin
                    if (!redirect_valid && count < FULL_COUNT) begin
                        state    <= BUSY;
                        req_addr <= fetch_pc;
                    end
                end
                BUSY: begin
                    if (imem_ack && redirect_valid) begin
                        state <= IDLE;
                    end else if (imem_ack) begin
                        fetch_pc <= next_pc;
                        req_addr <= next_pc;
                        state    <= stay_busy ? BUSY : IDLE;
                    end else if (redirect_valid) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // The stale request must still complete; its data is discarded.
                    if (imem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_pc    (fetch_pc),
        .push_instr (imem_rdata),
        .head_pc    (inst_pc),
        .head_instr (inst_data),
        .count      (count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized checks of instr_fetch_unit against a queue model
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, redirect_valid, imem_ack, inst_ready, imem_req, inst_valid;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, inst_data, inst_pc;
    logic        w_reset, w_req, w_valid;
    logic [31:0] w_addr, w_data, w_pc;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    bit mem_auto = 0;
    bit rand_data = 0;
    int ack_pct = 100;

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clock(clock), .reset(w_reset), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(w_addr),
        .inst_valid(w_valid), .inst_ready(1'b1), .inst_data(w_data), .inst_pc(w_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    // Reference: a queue of delivered words plus one outstanding request that may be marked dropped.
    fetch_entry_t q[$];
    logic [31:0]  m_fetch_pc = 32'h0;
    logic [31:0]  m_req_addr = 32'h0;
    bit           m_pending = 0;
    bit           m_dropped = 0;

    always @(posedge clock) begin
        int n;
        fetch_entry_t e;
        if (reset) begin
            q.delete();
            m_fetch_pc = 32'h0;
            m_req_addr = 32'h0;
            m_pending  = 0;
            m_dropped  = 0;
        end else begin
            n = q.size();
            if (redirect_valid) q.delete();
            else if (n > 0 && inst_ready) void'(q.pop_front());
            if (m_pending) begin
                if (imem_ack) begin
                    if (!m_dropped && !redirect_valid) begin
                        if (q.size() >= DEPTH) begin
                            errors++;
                            $display("FAIL model overflow: got %0d entries expected below %0d", q.size(), DEPTH);
                        end
                        e.pc = m_req_addr;
                        e.instr = imem_rdata;
                        q.push_back(e);
                        m_fetch_pc = m_fetch_pc + 32'd4;
                        m_req_addr = m_fetch_pc;
                        m_pending  = (q.size() < DEPTH);
                    end else begin
                        m_pending = 0;
                    end
                    m_dropped = 0;
                end else if (redirect_valid) begin
                    m_dropped = 1;
                end
            end else if (!redirect_valid && n < DEPTH) begin
                m_pending  = 1;
                m_req_addr = m_fetch_pc;
            end
            if (redirect_valid) m_fetch_pc = {redirect_pc[31:2], 2'b00};
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model imem_req", 32'(imem_req), 32'(m_pending));
            if (m_pending) chk("model imem_addr", imem_addr, m_req_addr);
            chk("model inst_valid", 32'(inst_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("model inst_pc", inst_pc, q[0].pc);
                chk("model inst_data", inst_data, q[0].instr);
            end
        end
    end

    always @(negedge clock) begin
        #1;
        if (mem_auto) begin
            imem_ack   = imem_req && ($urandom_range(99) < ack_pct);
            imem_rdata = rand_data ? $urandom : (imem_addr ^ KEY);
        end
    end

    task automatic do_reset;
        reset = 1; mem_auto = 0; imem_ack = 0; redirect_valid = 0;
        tick(); tick();
        reset = 0;
    endtask

    initial begin
        int n;
        int acks;
        bit seen;
        logic [31:0] first_addr;
        reset = 1; w_reset = 1; redirect_valid = 0; redirect_pc = 0;
        imem_ack = 0; imem_rdata = 0; inst_ready = 0;
        tick();
        chk_en = 1;
        chk("reset imem_req", 32'(imem_req), 32'd0);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset inst_valid", 32'(inst_valid), 32'd0);
        chk("reset inst_data", inst_data, 32'h0);
        chk("reset inst_pc", inst_pc, 32'h0);

        // Streaming at one instruction per cycle
        reset = 0; inst_ready = 1; mem_auto = 1; ack_pct = 100;
        tick();
        chk("latency req", 32'(imem_req), 32'd1);
        chk("latency addr", imem_addr, 32'h0);
        chk("latency valid low", 32'(inst_valid), 32'd0);
        tick();
        chk("latency valid high", 32'(inst_valid), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk("stream inst_pc", inst_pc, 32'(4 * k));
            chk("stream inst_data", inst_data, 32'(4 * k) ^ KEY);
            tick();
        end

        // Fill with decode stalled, then drain
        do_reset(); inst_ready = 0; mem_auto = 1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_ack) acks++;
        end
        chk("fill push count", 32'(acks), 32'd4);
        chk("fill req low", 32'(imem_req), 32'd0);
        chk("fill head pc", inst_pc, 32'h0);
        inst_ready = 1; seen = 0; first_addr = 32'h0;
        for (int k = 0; k < 4; k++) begin
            chk("drain head pc", inst_pc, 32'(4 * k));
            if (imem_req && !seen) begin seen = 1; first_addr = imem_addr; end
            tick();
        end
        chk("refetch addr", first_addr, 32'h10);

        // Redirect while a slow request is outstanding
        do_reset(); inst_ready = 1; mem_auto = 1;
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 50) begin tick(); n++; end
        chk("reach 0x8", imem_addr, 32'h8);
        mem_auto = 0; imem_ack = 0; redirect_valid = 1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 0;
        chk("flush hold req", 32'(imem_req), 32'd1);
        chk("flush hold addr", imem_addr, 32'h8);
        chk("flush fifo empty", 32'(inst_valid), 32'd0);
        tick();
        chk("flush hold addr 2", imem_addr, 32'h8);
        tick();
        chk("flush hold addr 3", imem_addr, 32'h8);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 0; mem_auto = 1;
        chk("flush done req", 32'(imem_req), 32'd0);
        chk("flush done valid", 32'(inst_valid), 32'd0);
        tick();
        chk("redirect req", 32'(imem_req), 32'd1);
        chk("redirect addr", imem_addr, 32'h100);
        tick();
        chk("redirect first pc", inst_pc, 32'h100);
        chk("redirect first data", inst_data, 32'h100 ^ KEY);

        // Redirect coinciding with ack, unaligned target
        chk("busy before coincide", 32'(imem_req), 32'd1);
        mem_auto = 0; imem_ack = 1; imem_rdata = 32'h1234_5678;
        redirect_valid = 1; redirect_pc = 32'h103;
        tick();
        imem_ack = 0; redirect_valid = 0; mem_auto = 1;
        chk("coincide req", 32'(imem_req), 32'd0);
        chk("coincide valid", 32'(inst_valid), 32'd0);
        tick();
        chk("coincide next addr", imem_addr, 32'h100);
        tick();
        chk("coincide first pc", inst_pc, 32'h100);

        // Reset with a request pending
        chk("busy before reset", 32'(imem_req), 32'd1);
        mem_auto = 0; imem_ack = 0; reset = 1;
        tick();
        chk("midreset req", 32'(imem_req), 32'd0);
        chk("midreset valid", 32'(inst_valid), 32'd0);
        chk("midreset addr", imem_addr, 32'h0);
        reset = 0; mem_auto = 1;
        tick();
        chk("restart req", 32'(imem_req), 32'd1);
        chk("restart addr", imem_addr, 32'h0);

        // Address wrap from a high reset PC
        w_reset = 0;
        tick();
        chk("wrap addr 0", w_addr, 32'hFFFF_FFF8);
        tick();
        chk("wrap addr 1", w_addr, 32'hFFFF_FFFC);
        chk("wrap head pc", w_pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap addr 2", w_addr, 32'h0000_0000);

        // Randomized traffic
        do_reset(); mem_auto = 1; rand_data = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) ack_pct = $urandom_range(20, 100);
            inst_ready     = ($urandom_range(99) < 60);
            redirect_valid = ($urandom_range(99) < 6);
            redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            reset          = ($urandom_range(999) < 4);
            tick();
        end
        reset = 0; redirect_valid = 0;
        tick(); tick();
        chk_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
